// File: rtl/m1_status_if.sv
// Status bundle between the M1 controller outputs and the board-facing display block.
// The master side drives T/V/D and observes the pins; the slave side is the display.
interface m1_status_if;
  logic       T;
  logic       V;
  logic [1:0] D;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic [3:0] led;

  modport master (output T, V, D, input seg, an, dp, led);
  modport slave  (input T, V, D, output seg, an, dp, led);
endinterface

// File: rtl/m1_status_display.sv
// Registers M1 controller status (T, V, D), mirrors it on LEDs and shows it on a
// 4-digit active-low multiplexed 7-segment display that blinks while V is high.
module m1_status_display #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input logic        clk,
  input logic        R,
  m1_status_if.slave sts
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic          t_r;
  logic          v_r;
  logic [1:0]    d_r;
  logic [RW-1:0] refresh_cnt_r;
  logic [1:0]    digit_idx_r;
  logic [BW-1:0] blink_cnt_r;
  logic          blink_ph_r;
  logic [6:0]    seg_r;
  logic [3:0]    an_r;
  logic          dp_r;
  logic [3:0]    led_r;

  logic          refresh_last_s;
  logic          blink_last_s;
  logic [6:0]    seg_nxt_s;
  logic [3:0]    an_nxt_s;

  // Segment pattern for one digit slot; digit 0 carries the coin count.
  function automatic logic [6:0] digit_code(input logic [1:0] idx, input logic t,
                                            input logic v, input logic [1:0] d);
    logic [6:0] code;
    case (idx)
      2'd3: code = t ? SEG_T : SEG_BLANK;
      2'd2: code = SEG_BLANK;
      2'd1: code = v ? SEG_U : SEG_BLANK;
      2'd0: begin
        case (d)
          2'd0:    code = SEG_0;
          2'd1:    code = SEG_1;
          2'd2:    code = SEG_2;
          2'd3:    code = SEG_DASH;
          default: code = SEG_DASH;
        endcase
      end
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  assign refresh_last_s = (refresh_cnt_r == REFRESH_LAST);
  assign blink_last_s   = (blink_cnt_r == BLINK_LAST);

  // Stage 1: capture controller status.
  always_ff @(posedge clk) begin
    if (R) begin
      t_r <= 1'b0;
      v_r <= 1'b0;
      d_r <= 2'd0;
    end else begin
      t_r <= sts.T;
      v_r <= sts.V;
      d_r <= sts.D;
    end
  end

  // Digit scan: advance one slot per REFRESH_DIV cycles, also while blanked.
  always_ff @(posedge clk) begin
    if (R) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= 2'd0;
    end else if (refresh_last_s) begin
      refresh_cnt_r <= '0;
      digit_idx_r   <= digit_idx_r + 2'd1;
    end else begin
      refresh_cnt_r <= refresh_cnt_r + RW'(1'b1);
    end
  end

  // Blink timer: runs only while V is held, cleared the cycle V drops.
  always_ff @(posedge clk) begin
    if (R) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
    end else if (!v_r) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= 1'b0;
    end else if (blink_last_s) begin
      blink_cnt_r <= '0;
      blink_ph_r  <= ~blink_ph_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BW'(1'b1);
    end
  end

  // Next display pattern; blank phase overrides anode selection.
  always_comb begin
    seg_nxt_s = SEG_BLANK;
    an_nxt_s  = 4'b1111;
    if (blink_ph_r) begin
      seg_nxt_s = SEG_BLANK;
      an_nxt_s  = 4'b1111;
    end else begin
      seg_nxt_s = digit_code(digit_idx_r, t_r, v_r, d_r);
      an_nxt_s  = ~(4'b0001 << digit_idx_r);
    end
  end

  // Stage 2: register every pin so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (R) begin
      seg_r <= SEG_BLANK;
      an_r  <= 4'b1111;
      dp_r  <= 1'b1;
      led_r <= 4'b0000;
    end else begin
      seg_r <= seg_nxt_s;
      an_r  <= an_nxt_s;
      dp_r  <= 1'b1;
      led_r <= {d_r, v_r, t_r};
    end
  end

  assign sts.seg = seg_r;
  assign sts.an  = an_r;
  assign sts.dp  = dp_r;
  assign sts.led = led_r;
endmodule

// File: tb/tb_m1_status_display.sv
// Directed vector bench for m1_status_display with REFRESH_DIV=4, BLINK_DIV=8.
module tb_m1_status_display;
  logic clk;
  logic R;
  m1_status_if sts ();

  m1_status_display #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk (clk),
    .R   (R),
    .sts (sts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       t;
    logic       v;
    logic [1:0] d;
    int         n;
    logic [6:0] seg;
    logic [3:0] an;
    logic [3:0] led;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;
  int   cnt;

  task automatic check(input string name, input logic [6:0] es, input logic [3:0] ea,
                       input logic [3:0] el);
    n_vec++;
    if (sts.seg !== es || sts.an !== ea || sts.led !== el || sts.dp !== 1'b1) begin
      n_err++;
      $display("FAIL %s: got seg=%h an=%h led=%h dp=%b, want seg=%h an=%h led=%h dp=1",
               name, sts.seg, sts.an, sts.led, sts.dp, es, ea, el);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    R = 1'b1; sts.T = 1'b1; sts.V = 1'b1; sts.D = 2'd2;

    // reset held, then released with T=1,V=1,D=2
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2'd2, 32'd3, 7'h7F, 4'hF, 4'h0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h40, 4'hE, 4'h0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h24, 4'hE, 4'hB});
    // scan with D=1 only
    vecs.push_back('{1'b1, 1'b0, 1'b0, 2'd1, 32'd1, 7'h7F, 4'hF, 4'h0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd1, 32'd1, 7'h40, 4'hE, 4'h0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd1, 32'd3, 7'h79, 4'hE, 4'h4});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd1, 32'd4, 7'h7F, 4'hD, 4'h4});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd1, 32'd4, 7'h7F, 4'hB, 4'h4});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd1, 32'd4, 7'h7F, 4'h7, 4'h4});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 2'd1, 32'd1, 7'h79, 4'hE, 4'h4});
    // ticket selected, D=0 then D=3
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 32'd1, 7'h79, 4'hE, 4'h4});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 32'd2, 7'h40, 4'hE, 4'h1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 32'd4, 7'h7F, 4'hD, 4'h1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 32'd4, 7'h7F, 4'hB, 4'h1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 32'd4, 7'h07, 4'h7, 4'h1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd3, 32'd1, 7'h40, 4'hE, 4'h1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd3, 32'd3, 7'h3F, 4'hE, 4'hD});
    // blink with T=1,V=1,D=2
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2'd2, 32'd1, 7'h7F, 4'hF, 4'h0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h40, 4'hE, 4'h0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd3, 7'h24, 4'hE, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd4, 7'h41, 4'hD, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h7F, 4'hB, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd8, 7'h7F, 4'hF, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd3, 7'h24, 4'hE, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd4, 7'h41, 4'hD, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h7F, 4'hB, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd2, 7'h7F, 4'hF, 4'hB});
    // V dropped during blank phase, then re-raised
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd2, 32'd1, 7'h7F, 4'hF, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd2, 32'd1, 7'h7F, 4'hF, 4'h9});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 2'd2, 32'd3, 7'h07, 4'h7, 4'h9});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h24, 4'hE, 4'h9});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd3, 7'h24, 4'hE, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd4, 7'h41, 4'hD, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h7F, 4'hB, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h7F, 4'hF, 4'hB});
    // one-cycle reset mid-blink at digit 2
    vecs.push_back('{1'b1, 1'b1, 1'b1, 2'd2, 32'd1, 7'h7F, 4'hF, 4'h0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h40, 4'hE, 4'h0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd3, 7'h24, 4'hE, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd4, 7'h41, 4'hD, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h7F, 4'hB, 4'hB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 32'd1, 7'h7F, 4'hF, 4'hB});

    for (int i = 0; i < vecs.size(); i++) begin
      R     = vecs[i].r;
      sts.T = vecs[i].t;
      sts.V = vecs[i].v;
      sts.D = vecs[i].d;
      for (int k = 0; k < vecs[i].n; k++) begin
        @(posedge clk);
        #1;
        check($sformatf("vec%0d.%0d", i, k), vecs[i].seg, vecs[i].an, vecs[i].led);
      end
    end

    // Hand sequence: visible/blank phase lengths measured from a fresh reset.
    R = 1'b1; sts.T = 1'b0; sts.V = 1'b1; sts.D = 2'd0;
    @(posedge clk);
    #1;
    check("seq_reset", 7'h7F, 4'hF, 4'h0);
    R = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (sts.an != 4'hF && cnt < 40);
    check_int("seq_first_blank_edge", cnt, 10);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (sts.an == 4'hF && cnt < 40);
    check_int("seq_blank_len", cnt, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
